// File: rtl/fb_pixel_writer_if.sv
// Pixel request channel from the ray-trace engine into the frame-buffer writer.
// Handshake: a pixel transfers on a rising clock edge when PIX_VALID and PIX_READY are both high;
// the master holds PIX_X/PIX_Y/PIX_COLOR stable while PIX_VALID is high and not yet accepted.
interface fb_pixel_writer_if #(
  parameter int DATA_W = 4
);
  logic              PIX_VALID;
  logic              PIX_READY;
  logic [9:0]        PIX_X;
  logic [9:0]        PIX_Y;
  logic [DATA_W-1:0] PIX_COLOR;

  modport master (output PIX_VALID, output PIX_X, output PIX_Y, output PIX_COLOR, input PIX_READY);
  modport slave  (input PIX_VALID, input PIX_X, input PIX_Y, input PIX_COLOR, output PIX_READY);
endinterface

// File: rtl/fb_pixel_writer.sv
// Write-side front end of the 4-bit frame buffer: queues pixel writes and issues them,
// or a whole-frame fill, only in the OCM write slot (SLOT == 2'b01).
module fb_pixel_writer #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [1:0]        SLOT,
  fb_pixel_writer_if.slave  PIX,
  input  logic              CLEAR_REQ,
  input  logic [DATA_W-1:0] CLEAR_COLOR,
  output logic              BUSY,
  output logic              CLEAR_DONE,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [DATA_W-1:0] WR_DATA,
  output logic [15:0]       DROP_CNT,
  output logic [1:0]        STATE_DBG
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  localparam int                PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]    DEPTH_V   = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] H_RES_A   = ADDR_W'(H_RES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

  state_t              state, state_d;
  logic [ADDR_W-1:0]   fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_data [FIFO_DEPTH];
  logic [PTR_W:0]      wr_ptr, rd_ptr, count, count_d;
  logic [PTR_W-1:0]    rd_idx;
  logic                empty, slot_wr;
  logic                accept, in_range, push, pop;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                clr_step;
  logic [ADDR_W-1:0]   clr_addr;
  logic [DATA_W-1:0]   clr_color;
  logic [ADDR_W-1:0]   pix_addr;
  logic [15:0]         drop_q;

  assign slot_wr  = (SLOT == 2'b01);
  assign count    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign rd_idx   = rd_ptr[PTR_W-1:0];

  assign accept   = PIX.PIX_VALID && ready_q;
  assign in_range = (int'(PIX.PIX_X) < H_RES) && (int'(PIX.PIX_Y) < V_RES);
  assign push     = accept && in_range;
  assign pix_addr = ADDR_W'(PIX.PIX_X) + H_RES_A * ADDR_W'(PIX.PIX_Y);

  assign count_d  = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  // Ready looks ahead at next-cycle state and occupancy so it can be a flop.
  assign ready_d  = (state_d == ST_IDLE) && (count_d != DEPTH_V);

  assign PIX.PIX_READY = ready_q;
  assign BUSY          = (state != ST_IDLE);
  assign CLEAR_DONE    = done_q;
  assign DROP_CNT      = drop_q;
  assign STATE_DBG     = state;

  always_comb begin
    state_d  = state;
    done_d   = 1'b0;
    pop      = 1'b0;
    clr_step = 1'b0;
    WR_EN    = 1'b0;
    WR_ADDR  = '0;
    WR_DATA  = '0;
    if (state != ST_CLEAR && slot_wr && !empty) begin
      pop     = 1'b1;
      WR_EN   = 1'b1;
      WR_ADDR = fifo_addr[rd_idx];
      WR_DATA = fifo_data[rd_idx];
    end
    unique case (state)
      ST_IDLE: begin
        if (CLEAR_REQ) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (empty) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (slot_wr) begin
          WR_EN    = 1'b1;
          WR_ADDR  = clr_addr;
          WR_DATA  = clr_color;
          clr_step = 1'b1;
          if (clr_addr == LAST_ADDR) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      clr_addr  <= '0;
      clr_color <= '0;
      drop_q    <= '0;
    end else begin
      state   <= state_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (clr_step) clr_addr <= done_d ? '0 : clr_addr + 1'b1;
      // The fill colour is only captured when the request is honoured.
      if (state == ST_IDLE && CLEAR_REQ) clr_color <= CLEAR_COLOR;
      if (accept && !in_range && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_addr[wr_ptr[PTR_W-1:0]] <= pix_addr;
      fifo_data[wr_ptr[PTR_W-1:0]] <= PIX.PIX_COLOR;
    end
  end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Bench for fb_pixel_writer: a full-size instance and an 8x4 instance for frame clears,
// checked against a pixel-level model of expected OCM writes.
module tb_fb_pixel_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  slot = 2'b00;
  bit          slot_run = 1'b1;
  int          cyc = 0;
  int          test_cnt = 0;
  int          fail_cnt = 0;
  int          exp_drop = 0;

  fb_pixel_writer_if pix_big ();
  fb_pixel_writer_if pix_small ();

  logic        clr_req_big = 1'b0, clr_req_small = 1'b0;
  logic [3:0]  clr_col_big = 4'h0, clr_col_small = 4'h0;
  logic        busy_big, busy_small, done_big, done_small, wr_en_big, wr_en_small;
  logic [18:0] wr_addr_big, wr_addr_small;
  logic [3:0]  wr_data_big, wr_data_small;
  logic [15:0] drop_big, drop_small;
  logic [1:0]  st_big, st_small;

  logic [22:0] exp_q[$];
  logic [22:0] obs_big[$];
  logic [22:0] obs_small[$];
  int          obs_big_cyc[$];

  fb_pixel_writer u_big (
    .CLK(clk), .RESET_N(rst_n), .SLOT(slot), .PIX(pix_big),
    .CLEAR_REQ(clr_req_big), .CLEAR_COLOR(clr_col_big),
    .BUSY(busy_big), .CLEAR_DONE(done_big), .WR_EN(wr_en_big),
    .WR_ADDR(wr_addr_big), .WR_DATA(wr_data_big), .DROP_CNT(drop_big), .STATE_DBG(st_big)
  );

  fb_pixel_writer #(.H_RES(8), .V_RES(4)) u_small (
    .CLK(clk), .RESET_N(rst_n), .SLOT(slot), .PIX(pix_small),
    .CLEAR_REQ(clr_req_small), .CLEAR_COLOR(clr_col_small),
    .BUSY(busy_small), .CLEAR_DONE(done_small), .WR_EN(wr_en_small),
    .WR_ADDR(wr_addr_small), .WR_DATA(wr_data_small), .DROP_CNT(drop_small), .STATE_DBG(st_small)
  );

  // Clock, cycle counter and free-running OCM slot counter (held at 00 when stopped)
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (slot_run) slot = slot + 2'd1;
      else          slot = 2'b00;
    end
  end

  // Observed OCM writes, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n && wr_en_big === 1'b1) begin
      obs_big.push_back({wr_addr_big, wr_data_big});
      obs_big_cyc.push_back(cyc);
    end
    if (rst_n && wr_en_small === 1'b1) obs_small.push_back({wr_addr_small, wr_data_small});
  end

  initial begin
    pix_big.PIX_VALID = 1'b0; pix_big.PIX_X = '0; pix_big.PIX_Y = '0; pix_big.PIX_COLOR = '0;
    pix_small.PIX_VALID = 1'b0; pix_small.PIX_X = '0; pix_small.PIX_Y = '0; pix_small.PIX_COLOR = '0;
  end

  // Reference model: a pixel becomes one write at x + H*y if in range, else a drop
  task automatic model_big(input int x, input int y, input logic [3:0] c);
    if (x < 640 && y < 480) exp_q.push_back({19'(x + 640 * y), c});
    else if (exp_drop < 65535) exp_drop++;
  endtask

  task automatic clear_obs();
    obs_big.delete(); obs_big_cyc.delete(); obs_small.delete(); exp_q.delete();
  endtask

  task automatic send_pix(input bit sel, input int x, input int y, input logic [3:0] c, output int acc);
    acc = -1;
    @(negedge clk);
    if (sel) begin
      pix_small.PIX_X = 10'(x); pix_small.PIX_Y = 10'(y); pix_small.PIX_COLOR = c; pix_small.PIX_VALID = 1'b1;
    end else begin
      pix_big.PIX_X = 10'(x); pix_big.PIX_Y = 10'(y); pix_big.PIX_COLOR = c; pix_big.PIX_VALID = 1'b1;
    end
    for (int i = 0; i < 200; i++) begin
      if ((sel ? pix_small.PIX_READY : pix_big.PIX_READY) === 1'b1) begin
        @(posedge clk);
        #1;
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    pix_small.PIX_VALID = 1'b0;
    pix_big.PIX_VALID = 1'b0;
    if (acc < 0) begin
      test_cnt++; fail_cnt++;
      $display("FAIL send_timeout: pixel (%0d,%0d) on sel %0d never accepted", x, y, sel);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    test_cnt++; if (pix_big.PIX_READY !== 1'b0) begin fail_cnt++; $display("FAIL reset_ready: got %b want 0", pix_big.PIX_READY); end
    test_cnt++; if (busy_big !== 1'b0) begin fail_cnt++; $display("FAIL reset_busy: got %b want 0", busy_big); end
    test_cnt++; if (done_big !== 1'b0) begin fail_cnt++; $display("FAIL reset_done: got %b want 0", done_big); end
    test_cnt++; if (drop_big !== 16'h0) begin fail_cnt++; $display("FAIL reset_drop: got %h want 0", drop_big); end
    test_cnt++; if (wr_en_big !== 1'b0) begin fail_cnt++; $display("FAIL reset_wr_en: got %b want 0", wr_en_big); end
    test_cnt++; if (wr_addr_big !== 19'h0) begin fail_cnt++; $display("FAIL reset_wr_addr: got %h want 0", wr_addr_big); end
    test_cnt++; if (wr_data_big !== 4'h0) begin fail_cnt++; $display("FAIL reset_wr_data: got %h want 0", wr_data_big); end
    test_cnt++; if (st_big !== 2'd0) begin fail_cnt++; $display("FAIL reset_state: got %0d want 0", st_big); end
    rst_n = 1'b1;
    #1;
    test_cnt++; if (pix_big.PIX_READY !== 1'b0) begin fail_cnt++; $display("FAIL ready_before_edge: got %b want 0", pix_big.PIX_READY); end
    @(negedge clk);
    test_cnt++; if (pix_big.PIX_READY !== 1'b1) begin fail_cnt++; $display("FAIL ready_after_release: got %b want 1", pix_big.PIX_READY); end
  endtask

  task automatic test_single();
    int acc;
    clear_obs();
    send_pix(1'b0, 3, 2, 4'hA, acc);
    repeat (10) @(negedge clk);
    test_cnt++; if (obs_big.size() != 1) begin fail_cnt++; $display("FAIL single_count: got %0d writes want 1", obs_big.size()); end
    if (obs_big.size() >= 1) begin
      test_cnt++; if (obs_big[0] !== {19'd1283, 4'hA}) begin fail_cnt++; $display("FAIL single_write: got addr %0d data %h want 1283 a", obs_big[0][22:4], obs_big[0][3:0]); end
      test_cnt++; if (obs_big_cyc[0] - acc < 0 || obs_big_cyc[0] - acc > 3) begin fail_cnt++; $display("FAIL single_latency: got %0d cycles want 0..3", obs_big_cyc[0] - acc); end
    end
  endtask

  task automatic test_boundary();
    int acc;
    clear_obs();
    model_big(639, 479, 4'h5); send_pix(1'b0, 639, 479, 4'h5, acc);
    model_big(640, 0, 4'h5);   send_pix(1'b0, 640, 0, 4'h5, acc);
    model_big(0, 480, 4'h5);   send_pix(1'b0, 0, 480, 4'h5, acc);
    repeat (12) @(negedge clk);
    test_cnt++; if (obs_big.size() != 1) begin fail_cnt++; $display("FAIL boundary_count: got %0d writes want 1", obs_big.size()); end
    if (obs_big.size() >= 1) begin
      test_cnt++; if (obs_big[0] !== {19'd307199, 4'h5}) begin fail_cnt++; $display("FAIL boundary_write: got addr %0d data %h want 307199 5", obs_big[0][22:4], obs_big[0][3:0]); end
    end
    test_cnt++; if (drop_big !== 16'd2) begin fail_cnt++; $display("FAIL boundary_drop: got %0d want 2", drop_big); end
  endtask

  task automatic test_random();
    int acc, x, y;
    logic [3:0] c;
    clear_obs();
    for (int i = 0; i < 24; i++) begin
      x = $urandom_range(0, 700); y = $urandom_range(0, 520); c = 4'($urandom_range(0, 15));
      model_big(x, y, c);
      send_pix(1'b0, x, y, c, acc);
    end
    for (int i = 0; i < 200 && obs_big.size() < exp_q.size(); i++) @(negedge clk);
    repeat (8) @(negedge clk);
    test_cnt++; if (obs_big.size() != exp_q.size()) begin fail_cnt++; $display("FAIL random_count: got %0d writes want %0d", obs_big.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_big.size(); i++) begin
      test_cnt++;
      if (obs_big[i] !== exp_q[i]) begin fail_cnt++; $display("FAIL random_write[%0d]: got %h want %h", i, obs_big[i], exp_q[i]); end
    end
    test_cnt++; if (drop_big !== 16'(exp_drop)) begin fail_cnt++; $display("FAIL random_drop: got %0d want %0d", drop_big, exp_drop); end
  endtask

  task automatic test_fifo_full();
    int acc, x, y;
    logic [3:0] c;
    clear_obs();
    @(negedge clk); slot_run = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      x = $urandom_range(0, 639); y = $urandom_range(0, 479); c = 4'(i + 1);
      model_big(x, y, c);
      send_pix(1'b0, x, y, c, acc);
    end
    repeat (2) @(negedge clk);
    test_cnt++; if (pix_big.PIX_READY !== 1'b0) begin fail_cnt++; $display("FAIL full_ready: got %b want 0", pix_big.PIX_READY); end
    test_cnt++; if (obs_big.size() != 0) begin fail_cnt++; $display("FAIL full_held_writes: got %0d want 0", obs_big.size()); end
    x = 100; y = 200; c = 4'hE;
    model_big(x, y, c);
    slot_run = 1'b1;
    send_pix(1'b0, x, y, c, acc);
    test_cnt++; if (obs_big.size() != 1) begin fail_cnt++; $display("FAIL ninth_timing: %0d writes before accept want 1", obs_big.size()); end
    if (obs_big_cyc.size() >= 1) begin
      test_cnt++; if (acc != obs_big_cyc[0] + 2) begin fail_cnt++; $display("FAIL ninth_cycle: got %0d want %0d", acc, obs_big_cyc[0] + 2); end
    end
    repeat (45) @(negedge clk);
    test_cnt++; if (obs_big.size() != 9) begin fail_cnt++; $display("FAIL full_count: got %0d writes want 9", obs_big.size()); end
    for (int i = 0; i < 9 && i < obs_big.size(); i++) begin
      test_cnt++;
      if (obs_big[i] !== exp_q[i]) begin fail_cnt++; $display("FAIL full_order[%0d]: got %h want %h", i, obs_big[i], exp_q[i]); end
    end
    for (int i = 0; i < 7 && i + 1 < obs_big_cyc.size(); i++) begin
      test_cnt++;
      if (obs_big_cyc[i+1] - obs_big_cyc[i] != 4) begin fail_cnt++; $display("FAIL full_spacing[%0d]: got %0d want 4", i, obs_big_cyc[i+1] - obs_big_cyc[i]); end
    end
  endtask

  task automatic test_clear();
    int acc, done_cnt, viol, post;
    bit sent2;
    clear_obs();
    @(negedge clk); slot_run = 1'b0;
    repeat (2) @(negedge clk);
    send_pix(1'b1, 1, 0, 4'h1, acc); exp_q.push_back({19'd1, 4'h1});
    send_pix(1'b1, 7, 3, 4'h2, acc); exp_q.push_back({19'd31, 4'h2});
    send_pix(1'b1, 2, 2, 4'h4, acc); exp_q.push_back({19'd18, 4'h4});
    for (int a = 0; a < 32; a++) exp_q.push_back({19'(a), 4'h3});
    @(negedge clk); clr_req_small = 1'b1; clr_col_small = 4'h3;
    @(negedge clk); clr_req_small = 1'b0; clr_col_small = 4'h0;
    test_cnt++; if (busy_small !== 1'b1) begin fail_cnt++; $display("FAIL clear_busy_rise: got %b want 1", busy_small); end
    slot_run = 1'b1;
    done_cnt = 0; viol = 0; post = 0; sent2 = 1'b0;
    for (int i = 0; i < 400 && post < 20; i++) begin
      @(negedge clk);
      clr_req_small = 1'b0;
      if (done_small === 1'b1) done_cnt++;
      if (done_cnt == 0 && (busy_small !== 1'b1 || pix_small.PIX_READY !== 1'b0)) viol++;
      if (done_cnt > 0) post++;
      if (!sent2 && obs_small.size() == 13) begin
        clr_req_small = 1'b1; clr_col_small = 4'h9; sent2 = 1'b1;
      end
    end
    test_cnt++; if (viol != 0) begin fail_cnt++; $display("FAIL clear_busy_ready: %0d cycles off, want 0", viol); end
    test_cnt++; if (done_cnt != 1) begin fail_cnt++; $display("FAIL clear_done_pulses: got %0d want 1", done_cnt); end
    test_cnt++; if (obs_small.size() != exp_q.size()) begin fail_cnt++; $display("FAIL clear_count: got %0d writes want %0d", obs_small.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_small.size(); i++) begin
      test_cnt++;
      if (obs_small[i] !== exp_q[i]) begin fail_cnt++; $display("FAIL clear_write[%0d]: got %h want %h", i, obs_small[i], exp_q[i]); end
    end
    test_cnt++; if (busy_small !== 1'b0 || pix_small.PIX_READY !== 1'b1) begin fail_cnt++; $display("FAIL clear_end: busy %b ready %b want 0 1", busy_small, pix_small.PIX_READY); end
  endtask

  task automatic test_reset_mid_clear();
    int acc;
    bit hit;
    clear_obs();
    @(negedge clk); clr_req_small = 1'b1; clr_col_small = 4'h6;
    @(negedge clk); clr_req_small = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wr_en_small === 1'b1 && wr_addr_small == 19'd10) begin hit = 1'b1; break; end
    end
    test_cnt++; if (!hit) begin fail_cnt++; $display("FAIL midclear_reach: clear address 10 never written"); end
    test_cnt++; if (wr_data_small !== 4'h6) begin fail_cnt++; $display("FAIL midclear_data: got %h want 6", wr_data_small); end
    rst_n = 1'b0;
    #1;
    test_cnt++; if (wr_en_small !== 1'b0) begin fail_cnt++; $display("FAIL midclear_wr_en: got %b want 0", wr_en_small); end
    test_cnt++; if (busy_small !== 1'b0) begin fail_cnt++; $display("FAIL midclear_busy: got %b want 0", busy_small); end
    @(negedge clk); rst_n = 1'b1; exp_drop = 0;
    clear_obs();
    send_pix(1'b0, 1, 1, 4'hF, acc);
    repeat (12) @(negedge clk);
    test_cnt++; if (obs_big.size() != 1 || obs_big[0] !== {19'd641, 4'hF}) begin fail_cnt++; $display("FAIL post_reset_pixel: got %0d writes first %h want 1 write %h", obs_big.size(), obs_big.size() > 0 ? obs_big[0] : 23'h0, {19'd641, 4'hF}); end
    test_cnt++; if (obs_small.size() != 0 || busy_small !== 1'b0) begin fail_cnt++; $display("FAIL no_clear_resume: got %0d writes busy %b want 0 0", obs_small.size(), busy_small); end
  endtask

  task automatic test_drop_saturate();
    int acc;
    clear_obs();
    @(negedge clk);
    pix_big.PIX_X = 10'd700; pix_big.PIX_Y = 10'd5; pix_big.PIX_COLOR = 4'h7; pix_big.PIX_VALID = 1'b1;
    acc = 0;
    for (int i = 0; i < 70000; i++) begin
      if (pix_big.PIX_READY === 1'b1) acc++;
      if (acc == 65537) break;
      @(negedge clk);
    end
    @(posedge clk); #1; pix_big.PIX_VALID = 1'b0;
    exp_drop = (exp_drop + acc > 65535) ? 65535 : exp_drop + acc;
    repeat (4) @(negedge clk);
    test_cnt++; if (acc != 65537) begin fail_cnt++; $display("FAIL drop_accepts: got %0d want 65537", acc); end
    test_cnt++; if (drop_big !== 16'(exp_drop)) begin fail_cnt++; $display("FAIL drop_saturate: got %h want %h", drop_big, 16'(exp_drop)); end
    test_cnt++; if (obs_big.size() != 0) begin fail_cnt++; $display("FAIL drop_no_write: got %0d writes want 0", obs_big.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_boundary();
    test_random();
    test_fifo_full();
    test_clear();
    test_reset_mid_clear();
    test_drop_saturate();
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", test_cnt + 1, fail_cnt + 1);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/fb_pixel_writer.md
Name: fb_pixel_writer

Overview:
- Write-side front end for the on-chip 4-bit frame buffer, feeding a single-port OCM.
- Accepts (x, y, colour) pixel writes from the ray-trace engine over a valid/ready handshake and buffers them in a small FIFO.
- Issues each buffered pixel as one OCM write, only in the write slot of the shared 4-phase OCM slot counter. The scanout read slot is never disturbed.
- Also provides a whole-frame clear command.

Parameters:
H_RES, 640, visible columns
V_RES, 480, visible rows
ADDR_W, 19, OCM address width
DATA_W, 4, pixel colour width
FIFO_DEPTH, 8, pending-write entries (power of 2)

Ports:
CLK  input  1  main clock
RESET_N  input  1  asynchronous active-low reset
SLOT  input  2  shared OCM phase counter; 2'b01 is the write slot
PIX_VALID  input  1  pixel request valid
PIX_READY  output  1  writer can accept a pixel this cycle
PIX_X  input  10  column
PIX_Y  input  10  row
PIX_COLOR  input  DATA_W  pixel colour
CLEAR_REQ  input  1  one-cycle request to fill the frame with CLEAR_COLOR
CLEAR_COLOR  input  DATA_W  fill colour, sampled with CLEAR_REQ
BUSY  output  1  high while a clear is draining or running
CLEAR_DONE  output  1  one-cycle pulse when the clear completes
WR_EN  output  1  OCM write enable
WR_ADDR  output  ADDR_W  OCM address
WR_DATA  output  DATA_W  OCM write data
DROP_CNT  output  16  count of out-of-range pixels discarded, saturating

Behaviour:
Reset (RESET_N low, takes effect immediately):
- FIFO empty, state IDLE, clear address 0.
- Outputs: PIX_READY 0, BUSY 0, CLEAR_DONE 0, DROP_CNT 0, WR_EN 0, WR_ADDR 0, WR_DATA 0.
- PIX_READY rises on the first clock edge after release.

Handshake:
- A transfer occurs on a rising CLK edge when PIX_VALID and PIX_READY are both high.
- PIX_READY = (state == IDLE) and FIFO not full. It is registered, so a pop in the same cycle does not allow a push into a full FIFO.

Ingress address:
- addr = PIX_X + H_RES*PIX_Y, computed at ADDR_W width; no truncation for in-range inputs.
- Pixels with PIX_X >= H_RES or PIX_Y >= V_RES complete the handshake but are discarded; DROP_CNT increments and saturates at 16'hFFFF.

Write issue (IDLE and DRAIN states):
- WR_EN, WR_ADDR and WR_DATA are combinational.
- When SLOT == 2'b01 and the FIFO is non-empty: WR_EN = 1, and WR_ADDR/WR_DATA = FIFO head. The head pops at that edge.
- Otherwise WR_EN = 0, WR_ADDR = 0, WR_DATA = 0.
- At most one write per 4-cycle slot period; writes are in strict FIFO order.
- Push and pop in the same cycle leave the occupancy unchanged.

State machine:
- IDLE -> DRAIN on CLEAR_REQ; latch CLEAR_COLOR and raise BUSY.
- DRAIN: PIX_READY held 0 while the remaining FIFO entries are written. Go to CLEAR on the cycle the FIFO is empty.
- CLEAR: on each SLOT == 2'b01 cycle, write the latched colour to the clear address, then increment it.
  - Addresses run 0 .. H_RES*V_RES-1.
  - After the last address is written: return to IDLE, clear address back to 0, BUSY drops and CLEAR_DONE pulses for one cycle.
- CLEAR_REQ while BUSY is ignored; the latched colour is not changed.
- A full 640x480 clear takes 307200 writes, i.e. 1228800 cycles after the FIFO has drained.

Test Plan:
- SLOT free-running 00..11; accept (3,2,4'hA) -> exactly one WR_EN pulse at the next SLOT == 01, WR_ADDR 1283, WR_DATA 4'hA, within 4 cycles of acceptance.
- Pixel (639,479,4'h5) -> write to WR_ADDR 307199. Pixel (640,0,4'h5) and pixel (0,480,4'h5) -> no write, DROP_CNT = 2.
- Hold SLOT = 00 and offer 9 pixels -> PIX_READY low after the 8th is accepted. Then run SLOT -> 8 writes in push order, 4 cycles apart; the 9th is accepted the cycle after PIX_READY rises.
- H_RES=8, V_RES=4 with 3 pixels queued, then CLEAR_REQ with colour 4'h3 -> the 3 pixel writes come first, then 32 writes of 4'h3 to addresses 0..31. PIX_READY stays 0 and BUSY stays 1 throughout, then CLEAR_DONE pulses once.
  - A second CLEAR_REQ (colour 4'h9) mid-clear changes nothing.
- Drop RESET_N at clear address 10 -> WR_EN 0 and BUSY 0 immediately. After release, a single pixel (1,1,4'hF) writes WR_ADDR 641 and no clear resumes.
- Send 65537 out-of-range pixels -> DROP_CNT holds 16'hFFFF and WR_EN never asserts.
